// File: rtl/sliding_window_sum.sv
// sliding_window_sum: strobe-gated running sum and average over the last 2^WINDOW_SHIFT accepted samples
module sliding_window_sum #(
    parameter int DATA_WIDTH   = 32,
    parameter int WINDOW_SHIFT = 4
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        enable,
    input  logic                                        clear,
    input  logic signed [DATA_WIDTH-1:0]                data_in,
    input  logic                                        input_strobe,
    output logic signed [DATA_WIDTH+WINDOW_SHIFT-1:0]   sum_out,
    output logic signed [DATA_WIDTH-1:0]                avg_out,
    output logic                                        window_full,
    output logic                                        output_strobe
);
    localparam int N  = 1 << WINDOW_SHIFT;
    localparam int AW = DATA_WIDTH + WINDOW_SHIFT;

    logic signed [DATA_WIDTH-1:0] ring [N];
    logic        [WINDOW_SHIFT-1:0] wr_ptr, base_ptr, ptr_n;
    logic        [WINDOW_SHIFT:0]   fill, base_fill, fill_n;
    logic signed [AW-1:0]           base_acc, acc_n;
    logic signed [DATA_WIDTH-1:0]   old;
    logic                           accept, restart;

    assign accept  = enable & input_strobe & ~reset;
    assign restart = enable & clear;

    // a restart discards history so a colliding sample becomes the first of the new window
    always_comb begin
        base_acc  = restart ? '0 : sum_out;
        base_fill = restart ? '0 : fill;
        base_ptr  = restart ? '0 : wr_ptr;
        old       = (!restart && fill[WINDOW_SHIFT]) ? ring[wr_ptr] : '0;
        acc_n     = base_acc + {{WINDOW_SHIFT{data_in[DATA_WIDTH-1]}}, data_in}
                             - {{WINDOW_SHIFT{old[DATA_WIDTH-1]}}, old};
        fill_n    = base_fill[WINDOW_SHIFT] ? base_fill : base_fill + 1'b1;
        ptr_n     = base_ptr + 1'b1;
    end

    // sample storage is never cleared; fill gates which entries are subtracted
    always_ff @(posedge clock) begin
        if (accept) ring[base_ptr] <= data_in;
    end

    // window state and output strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_out       <= '0;
            fill          <= '0;
            wr_ptr        <= '0;
            output_strobe <= 1'b0;
        end else begin
            output_strobe <= accept;
            if (accept) begin
                sum_out <= acc_n;
                fill    <= fill_n;
                wr_ptr  <= ptr_n;
            end else if (restart) begin
                sum_out <= '0;
                fill    <= '0;
                wr_ptr  <= '0;
            end
        end
    end

    assign avg_out     = sum_out[AW-1:WINDOW_SHIFT];
    assign window_full = fill[WINDOW_SHIFT];
endmodule
